// File: rtl/eng_sched_if.sv
// Requester/engine-side bundle for eng_sched: request and length inputs, grant and completion
// outputs, and the go/ack/en/done handshake to the shared compute engine.
interface eng_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 8
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*CNT_WIDTH-1:0] len;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done_out;
  logic                         busy;
  logic                         err;
  logic                         eng_go;
  logic                         eng_ack;
  logic                         eng_en;
  logic                         eng_done;

  // master = requesters plus engine; slave = the scheduler
  modport master (
    output req, len, eng_en, eng_done,
    input  grant, done_out, busy, err, eng_go, eng_ack
  );
  modport slave (
    input  req, len, eng_en, eng_done,
    output grant, done_out, busy, err, eng_go, eng_ack
  );
endinterface

// File: rtl/eng_sched.sv
// Round-robin scheduler sharing one go/ack/en/done engine among NUM_REQ requesters.
// Define ENG_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module eng_sched #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  eng_sched_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, RELEASE} state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg;
  logic [CNT_WIDTH-1:0] len_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 err_reg;
  logic [CNT_WIDTH-1:0] len_slice [NUM_REQ];
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic                 ack;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_len
      assign len_slice[gi] = bus.len[gi*CNT_WIDTH +: CNT_WIDTH];
    end
  endgenerate

`ifdef ENG_SCHED_FIXED_PRIO_EN
  always_comb begin
    win_idx   = '0;
    win_found = |bus.req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[k]) win_idx = IDX_W'(k);
    end
  end
`else
  logic [IDX_W-1:0] last_reg;
  logic [IDX_W-1:0] cand;

  // Search starts just past the previous winner so every requester gets a turn.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_reg) + k) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_reg <= IDX_W'(NUM_REQ - 1);
    else if (state_reg == IDLE && win_found) last_reg <= win_idx;
  end
`endif

  // Ack comes from registers only, so it never loops through the engine's en.
  assign ack      = (cnt_reg == len_reg);
  assign bus.busy = (state_reg != IDLE);
  assign bus.err  = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    bus.grant    = '0;
    bus.done_out = '0;
    bus.eng_go   = 1'b0;
    bus.eng_ack  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) state_next = ISSUE;
      end
      ISSUE: begin
        bus.grant  = grant_reg;
        bus.eng_go = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        bus.grant   = grant_reg;
        bus.eng_go  = 1'b1;
        bus.eng_ack = ack;
        if (ack) state_next = RELEASE;
      end
      RELEASE: begin
        bus.grant    = grant_reg;
        bus.done_out = grant_reg;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_reg <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE && win_found) begin
        grant_reg <= NUM_REQ'(1) << win_idx;
        len_reg   <= len_slice[win_idx];
      end
      if (state_reg == ISSUE)
        cnt_reg <= '0;
      else if (state_reg == RUN && bus.eng_en && !ack)
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      // en outside the compute window, or no done alongside ack, is a broken handshake
      if (((state_reg == ISSUE || state_reg == RELEASE) && bus.eng_en) ||
          (state_reg == RUN && ack && !bus.eng_done))
        err_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_eng_sched.sv
// Directed bench for eng_sched with a small go/ack/en/done engine model attached.
module tb_eng_sched;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kill_done = 1'b0;
  logic err_exp = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   en_total = 0;

  eng_sched_if #(.NUM_REQ(N), .CNT_WIDTH(W)) bus ();
  eng_sched #(.NUM_REQ(N), .CNT_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // engine: waits for go, computes until ack, then waits for go to drop
  typedef enum logic [1:0] {E_IDLE, E_COMP, E_FIN} est_t;
  est_t est;
  always @(posedge clk or posedge rst) begin
    if (rst) est <= E_IDLE;
    else begin
      case (est)
        E_IDLE:  if (bus.eng_go) est <= E_COMP;
        E_COMP:  if (bus.eng_ack) est <= E_FIN;
        E_FIN:   if (!bus.eng_go) est <= E_IDLE;
        default: est <= E_IDLE;
      endcase
    end
  end
  assign bus.eng_en   = (est == E_COMP) && !bus.eng_ack;
  assign bus.eng_done = (est == E_COMP) && bus.eng_ack && !kill_done;

  always @(posedge clk) if (bus.eng_en) en_total <= en_total + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "/grant"}, 32'(bus.grant), 32'(0));
    chk({tag, "/done_out"}, 32'(bus.done_out), 32'(0));
    chk({tag, "/busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "/err"}, 32'(bus.err), 32'(0));
    chk({tag, "/go"}, 32'(bus.eng_go), 32'(0));
    chk({tag, "/ack"}, 32'(bus.eng_ack), 32'(0));
  endtask

  // Called while DUT is in IDLE with req already applied; returns in the following IDLE cycle.
  task automatic job(input string tag, input logic [N-1:0] g, input int n, input logic [N-1:0] req_after);
    int en0;
    en0 = en_total;
    step();
    chk({tag, "/issue_grant"}, 32'(bus.grant), 32'(g));
    chk({tag, "/issue_busy"}, 32'(bus.busy), 32'(1));
    chk({tag, "/issue_go"}, 32'(bus.eng_go), 32'(1));
    chk({tag, "/issue_ack"}, 32'(bus.eng_ack), 32'(0));
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "/run_en"}, 32'(bus.eng_en), 32'(1));
      chk({tag, "/run_ack"}, 32'(bus.eng_ack), 32'(0));
      chk({tag, "/run_grant"}, 32'(bus.grant), 32'(g));
    end
    step();
    chk({tag, "/ack"}, 32'(bus.eng_ack), 32'(1));
    chk({tag, "/ack_en"}, 32'(bus.eng_en), 32'(0));
    chk({tag, "/ack_go"}, 32'(bus.eng_go), 32'(1));
    chk({tag, "/ack_err"}, 32'(bus.err), 32'(err_exp));
    err_exp = err_exp | kill_done;
    step();
    chk({tag, "/rel_done_out"}, 32'(bus.done_out), 32'(g));
    chk({tag, "/rel_go"}, 32'(bus.eng_go), 32'(0));
    chk({tag, "/rel_ack"}, 32'(bus.eng_ack), 32'(0));
    chk({tag, "/rel_grant"}, 32'(bus.grant), 32'(g));
    chk({tag, "/rel_err"}, 32'(bus.err), 32'(err_exp));
    bus.req = req_after;
    step();
    chk({tag, "/idle_grant"}, 32'(bus.grant), 32'(0));
    chk({tag, "/idle_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "/idle_done_out"}, 32'(bus.done_out), 32'(0));
    chk({tag, "/en_cycles"}, 32'(en_total - en0), 32'(n));
    $display("job %s grant=%b len=%0d en_cycles=%0d err=%0b", tag, g, n, en_total - en0, bus.err);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    err_exp = 1'b0;
    step();
    chk_idle_outputs(tag);
    rst = 1'b0;
    $display("reset %s", tag);
  endtask

  initial begin
    bus.req = '0;
    bus.len = '0;
    do_reset("init");

    // single job, len 3
    bus.req = 4'b0001;
    bus.len = {8'd0, 8'd0, 8'd0, 8'd3};
    job("single", 4'b0001, 3, 4'b0000);

    // zero length
    bus.req = 4'b0010;
    bus.len = {8'd0, 8'd0, 8'd0, 8'd0};
    job("zero_len", 4'b0010, 0, 4'b0000);

    // round-robin with all requesters held
    do_reset("rr");
    bus.req = 4'b1111;
    bus.len = {8'd1, 8'd1, 8'd1, 8'd1};
`ifdef ENG_SCHED_FIXED_PRIO_EN
    job("rr0", 4'b0001, 1, 4'b1111);
    job("rr1", 4'b0001, 1, 4'b1111);
    job("rr2", 4'b0001, 1, 4'b1111);
    job("rr3", 4'b0001, 1, 4'b1111);
    job("rr4", 4'b0001, 1, 4'b0000);
`else
    job("rr0", 4'b0001, 1, 4'b1111);
    job("rr1", 4'b0010, 1, 4'b1111);
    job("rr2", 4'b0100, 1, 4'b1111);
    job("rr3", 4'b1000, 1, 4'b1111);
    job("rr4", 4'b0001, 1, 4'b0000);
`endif

    // requester 2 drops req in its done_out cycle while 3 is waiting
    do_reset("drop");
    bus.req = 4'b1100;
    bus.len = {8'd1, 8'd2, 8'd0, 8'd0};
    job("drop2", 4'b0100, 2, 4'b1000);
    job("then3", 4'b1000, 1, 4'b0000);
    step();
    chk("drop/no_repeat_grant", 32'(bus.grant), 32'(0));
    chk("drop/no_repeat_busy", 32'(bus.busy), 32'(0));

    // asynchronous reset in RUN with cnt=2, len=5
    bus.req = 4'b0001;
    bus.len = {8'd0, 8'd0, 8'd0, 8'd5};
    step();
    step();
    step();
    step();
    chk("midrst/pre_busy", 32'(bus.busy), 32'(1));
    chk("midrst/pre_en", 32'(bus.eng_en), 32'(1));
    rst = 1'b1;
    err_exp = 1'b0;
    #1;
    chk_idle_outputs("midrst_async");
    step();
    chk_idle_outputs("midrst_held");
    rst = 1'b0;
    $display("reset midrst");
    job("resume", 4'b0001, 5, 4'b0000);

    // protocol error: engine withholds done in the ack cycle
    kill_done = 1'b1;
    bus.req = 4'b0001;
    bus.len = {8'd0, 8'd0, 8'd0, 8'd2};
    job("perr", 4'b0001, 2, 4'b0000);
    kill_done = 1'b0;
    step();
    chk("perr/sticky", 32'(bus.err), 32'(1));
    bus.req = 4'b0001;
    job("perr_after", 4'b0001, 2, 4'b0000);
    chk("perr/still_set", 32'(bus.err), 32'(1));
    do_reset("perr_clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eng_sched.md
# eng_sched

Round-robin scheduler that shares one go/ack/en/done compute engine among NUM_REQ requesters. It grants the engine to one requester at a time and drives the engine's go and ack. It counts the engine's en cycles against the winner's requested work length, so each job gets exactly that many enable cycles. The block sits between the requester ports and the single engine instance.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- CNT_WIDTH, 8, width of per-requester work length and internal en counter
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  level request per requester; held until its done_out pulse
- len  in  NUM_REQ*CNT_WIDTH  work length per requester, slice i = len[i*CNT_WIDTH +: CNT_WIDTH]; sampled at grant
- grant  out  NUM_REQ  one-hot owner of the engine, 0 when idle
- done_out  out  NUM_REQ  one-cycle completion pulse to the owner
- busy  out  1  state != IDLE
- err  out  1  sticky protocol-error flag
- eng_go  out  1  go to engine
- eng_ack  out  1  ack to engine
- eng_en  in  1  engine enable (engine output)
- eng_done  in  1  engine done (engine output)

## Operation
- States: IDLE, ISSUE, RUN, RELEASE; all registered. Outputs are decoded from registered state only.
- IDLE: eng_go=0, grant=0.
  - If any req bit is set, select a winner w, latch len_r=len[w], and latch the one-hot grant. Go to ISSUE.
- ISSUE: eng_go=1, eng_ack=0. One cycle, while the engine leaves START/RESTART for COMPUTE. Clear cnt. Go to RUN.
- RUN: eng_go=1.
  - eng_ack = (cnt == len_r). It depends only on registers, never on eng_en, which avoids a combinational loop through the engine.
  - cnt increments on each cycle with eng_en=1 and eng_ack=0.
  - When eng_ack=1, go to RELEASE.
- RELEASE: eng_go=0, which moves the engine from FINISH to RESTART. done_out[w]=1 for this cycle. grant is held. Go to IDLE.
- Round-robin arbitration:
  - Pointer last_r holds the index of the previous winner.
  - Search order is last_r+1, last_r+2, … modulo NUM_REQ.
  - last_r updates on the IDLE→ISSUE transition.
  - Reset value of last_r is NUM_REQ-1, so req[0] has first priority.
- Work length:
  - len_r=0 is legal: ack is asserted in the first RUN cycle, and the engine gives zero en cycles.
  - cnt never exceeds len_r, so there is no wrap-around.
- If a requester keeps req high in the done_out cycle, that is a new job. It is arbitrated in the following IDLE cycle.
- err is set, and held until reset, in either case:
  - eng_en=1 while in ISSUE or RELEASE;
  - eng_done=0 in a RUN cycle where eng_ack=1.
- Reset: applies immediately, including mid-job.
  - Returns to IDLE with cnt=0 and last_r=NUM_REQ-1.
  - Outputs grant, done_out, busy, err, eng_go and eng_ack are all 0.
  - The engine shares rst, so both restart together.

## Timing
- A request seen in IDLE at cycle c gives:
  - c+1: ISSUE; grant and busy valid; eng_go=1.
  - c+2 … c+1+len: eng_en=1 from the engine.
  - c+2+len: eng_ack=1; engine done=1.
  - c+3+len: RELEASE; done_out pulse; eng_go=0.
  - c+4+len: IDLE; grant=0. The earliest next grant is at c+5+len.
- Per-job overhead: 4 cycles beyond len.
- Back-to-back throughput: one job every len+4 cycles.
- Request changes during a job are ignored until IDLE. len is not re-sampled during a job.

## Configuration
- ENG_SCHED_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins. last_r is not implemented, and starvation is permitted.
  - Undefined (default): round-robin as described above.

## Test plan
- Single job:
  - Stimulus: req=0001, len[0]=3, with an engine model attached.
  - Required: grant=0001 one cycle later; exactly 3 eng_en cycles; eng_ack one cycle; done_out[0] at c+6; busy low at c+7; err=0.
- Zero length:
  - Stimulus: req=0010, len[1]=0.
  - Required: no eng_en cycles; eng_ack in the first RUN cycle; done_out[1] at c+3; err=0.
- Round-robin:
  - Stimulus: req=1111 held, all len=1.
  - Required: grant order 0001, 0010, 0100, 1000, 0001; one job every 5 cycles.
  - With ENG_SCHED_FIXED_PRIO_EN defined: always 0001.
- Release on done:
  - Stimulus: req[2] dropped in its done_out cycle while req[3] is high.
  - Required: next grant=1000, with no repeat job for requester 2.
- Reset mid-operation:
  - Stimulus: assert rst in RUN with cnt=2, len=5.
  - Required: all outputs 0 immediately. After release with req=0001, the job completes normally with 5 en cycles.
- Protocol error:
  - Stimulus: force eng_done=0 during the ack cycle.
  - Required: err=1 from the next cycle, held until rst.
